// File: rtl/rat_pipe_pkg.sv
// Shared types and constants for the decode/issue hazard logic.
// Holds the FSM state, the scoreboard entry and the register-address helpers.
package rat_pipe_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned PC_W      = 10;

   typedef enum logic [1:0] {
      RUN,
      BR_WAIT,
      FLUSH,
      INT_ENTRY
   } hz_state_t;

   typedef struct packed {
      logic                 v;
      logic [RF_ADDR_W-1:0] addr;
   } sb_entry_t;

   // True when a pending write targets the given source register
   function automatic logic sb_match(sb_entry_t e, logic [RF_ADDR_W-1:0] a);
      return e.v && (e.addr == a);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and control-vector-register command signals of hazard_ctrl.
// master is the pipeline side, slave is the controller.
interface hazard_ctrl_if;
   import rat_pipe_pkg::*;

   logic                 id_valid;
   logic [RF_ADDR_W-1:0] id_x_addr;
   logic                 id_x_used;
   logic [RF_ADDR_W-1:0] id_y_addr;
   logic                 id_y_used;
   logic                 id_rf_wr;
   logic [RF_ADDR_W-1:0] id_wb_addr;
   logic                 id_is_branch;
   logic                 ex_br_resolved;
   logic                 ex_br_taken;
   logic                 int_req;
   logic                 int_en;

   logic                 nop;
   logic                 interupt;
   logic                 pc_stall;
   logic                 if_flush;
   logic                 int_ack;

   modport master (
      output id_valid, id_x_addr, id_x_used, id_y_addr, id_y_used,
             id_rf_wr, id_wb_addr, id_is_branch, ex_br_resolved,
             ex_br_taken, int_req, int_en,
      input  nop, interupt, pc_stall, if_flush, int_ack
   );

   modport slave (
      input  id_valid, id_x_addr, id_x_used, id_y_addr, id_y_used,
             id_rf_wr, id_wb_addr, id_is_branch, ex_br_resolved,
             ex_br_taken, int_req, int_en,
      output nop, interupt, pc_stall, if_flush, int_ack
   );

endinterface

// File: rtl/wb_scoreboard.sv
// Shift register of in-flight RF writes with a two-port source-address compare.
// An entry stays visible for exactly DEPTH cycles after its issue cycle.
module wb_scoreboard
   import rat_pipe_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  sb_entry_t            push_i,
   input  logic [RF_ADDR_W-1:0] x_addr_i,
   input  logic [RF_ADDR_W-1:0] y_addr_i,
   output logic                 hit_x_o,
   output logic                 hit_y_o
);

   sb_entry_t sb_q [DEPTH];
   sb_entry_t sb_d [DEPTH];

   always_comb begin
      sb_d[0] = push_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   // The oldest entry still compares, so a hazard on its last cycle stalls
   always_comb begin
      hit_x_o = 1'b0;
      hit_y_o = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hit_x_o = hit_x_o | sb_match(sb_q[i], x_addr_i);
         hit_y_o = hit_y_o | sb_match(sb_q[i], y_addr_i);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/bubble/interrupt-injection decision for the decode/execute control-vector
// register, with RAW stall, branch wait, fetch flush and interrupt entry sequencing.
module hazard_ctrl
   import rat_pipe_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH   = 2,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
);

   localparam int unsigned CNT_W = 2;

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic      hit_x, hit_y;
   logic      raw_c;
   logic      issue_c;
   logic      inject_c;
   logic      pc_stall_c;
   logic      if_flush_c;
   sb_entry_t push_c;

   wb_scoreboard #(
      .DEPTH (PIPE_DEPTH)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push_c),
      .x_addr_i (hz.id_x_addr),
      .y_addr_i (hz.id_y_addr),
      .hit_x_o  (hit_x),
      .hit_y_o  (hit_y)
   );

   assign raw_c = hz.id_valid & ((hz.id_x_used & hit_x) | (hz.id_y_used & hit_y));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and per-cycle issue decision
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      issue_c    = 1'b0;
      inject_c   = 1'b0;
      pc_stall_c = 1'b0;
      if_flush_c = 1'b0;

      unique case (state_q)
         RUN: begin
            if (hz.int_req && hz.int_en && !raw_c && hz.id_valid && !hz.id_is_branch) begin
               inject_c   = 1'b1;
               pc_stall_c = 1'b1;
               state_d    = INT_ENTRY;
            end else if (raw_c) begin
               pc_stall_c = 1'b1;
            end else if (hz.id_valid) begin
               issue_c = 1'b1;
               if (hz.id_is_branch) begin
                  state_d = BR_WAIT;
               end
            end
         end
         BR_WAIT: begin
            if (!hz.ex_br_resolved) begin
               pc_stall_c = 1'b1;
            end else if (hz.ex_br_taken) begin
               if_flush_c = 1'b1;
               cnt_d      = CNT_W'(FLUSH_CYCLES);
               state_d    = FLUSH;
            end else begin
               // Fall-through: decode's instruction may go out in the resolve cycle
               state_d = RUN;
               if (raw_c) begin
                  pc_stall_c = 1'b1;
               end else if (hz.id_valid) begin
                  issue_c = 1'b1;
                  if (hz.id_is_branch) begin
                     state_d = BR_WAIT;
                  end
               end
            end
         end
         FLUSH: begin
            if_flush_c = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         INT_ENTRY: begin
            if_flush_c = 1'b1;
            cnt_d      = CNT_W'(FLUSH_CYCLES);
            state_d    = FLUSH;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Injected interrupt slots and bubbles never mark the scoreboard
   always_comb begin
      push_c      = '0;
      push_c.v    = issue_c & hz.id_rf_wr;
      push_c.addr = issue_c ? hz.id_wb_addr : '0;
   end

   assign hz.nop      = rst_n ? ~(issue_c | inject_c) : 1'b1;
   assign hz.interupt = rst_n & inject_c;
   assign hz.int_ack  = rst_n & inject_c;
   assign hz.pc_stall = rst_n & pc_stall_c;
   assign hz.if_flush = rst_n & if_flush_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: literal checks at key cycles plus a
// queue-based reference model compared on every out-of-reset cycle.
module tb_hazard_ctrl;

   localparam int unsigned PIPE_DEPTH   = 2;
   localparam int unsigned FLUSH_CYCLES = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

   hazard_ctrl #(
      .PIPE_DEPTH   (PIPE_DEPTH),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   int checks = 0;
   int errors = 0;

   // Output vector order: {nop, interupt, pc_stall, if_flush, int_ack}
   function automatic logic [4:0] outs();
      return {hz.nop, hz.interupt, hz.pc_stall, hz.if_flush, hz.int_ack};
   endfunction

   function automatic logic [4:0] o(bit n, bit i, bit s, bit f, bit a);
      return {n, i, s, f, a};
   endfunction

   task automatic lit(string name, logic [4:0] exp);
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", name, outs(), exp);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_cyc;
   int         m_wc[$];
   logic [4:0] m_wa[$];
   bit         m_br;
   int         m_fl;
   bit         m_ie;

   // A write issued in cycle c is visible to decode in cycles c+1 .. c+PIPE_DEPTH
   function automatic bit m_hit(logic [4:0] a);
      foreach (m_wc[k]) begin
         if ((m_cyc - m_wc[k]) >= 1 && (m_cyc - m_wc[k]) <= int'(PIPE_DEPTH) && m_wa[k] == a)
            return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cyc = 0;
         m_wc.delete();
         m_wa.delete();
         m_br  = 1'b0;
         m_fl  = 0;
         m_ie  = 1'b0;
      end else begin
         logic [4:0] e;
         bit raw, iss, acc;
         bit en, ei, es, ef, ea;
         en = 1'b1; ei = 1'b0; es = 1'b0; ef = 1'b0; ea = 1'b0; iss = 1'b0;
         raw = hz.id_valid && ((hz.id_x_used && m_hit(hz.id_x_addr)) ||
                               (hz.id_y_used && m_hit(hz.id_y_addr)));
         if (m_ie) begin
            ef = 1'b1; m_ie = 1'b0; m_fl = int'(FLUSH_CYCLES);
         end else if (m_fl > 0) begin
            ef = 1'b1; m_fl = m_fl - 1;
         end else if (m_br && !hz.ex_br_resolved) begin
            es = 1'b1;
         end else if (m_br && hz.ex_br_taken) begin
            ef = 1'b1; m_br = 1'b0; m_fl = int'(FLUSH_CYCLES);
         end else begin
            acc  = !m_br && hz.int_req && hz.int_en && !raw && hz.id_valid && !hz.id_is_branch;
            m_br = 1'b0;
            if (acc) begin
               en = 1'b0; ei = 1'b1; ea = 1'b1; es = 1'b1; m_ie = 1'b1;
            end else if (raw) begin
               es = 1'b1;
            end else if (hz.id_valid) begin
               iss = 1'b1; en = 1'b0;
               if (hz.id_is_branch) m_br = 1'b1;
            end
         end
         e = o(en, ei, es, ef, ea);
         checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL model cyc=%0d act=%b exp=%b", m_cyc, outs(), e);
         end
         if (iss && hz.id_rf_wr) begin
            m_wc.push_back(m_cyc);
            m_wa.push_back(hz.id_wb_addr);
         end
         m_cyc++;
         while (m_wc.size() > 0 && (m_cyc - m_wc[0]) > int'(PIPE_DEPTH)) begin
            void'(m_wc.pop_front());
            void'(m_wa.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(bit v, logic [4:0] xa, bit xu, logic [4:0] ya, bit yu,
                      bit wr, logic [4:0] wa, bit br);
      hz.id_valid     = v;
      hz.id_x_addr    = xa;
      hz.id_x_used    = xu;
      hz.id_y_addr    = ya;
      hz.id_y_used    = yu;
      hz.id_rf_wr     = wr;
      hz.id_wb_addr   = wa;
      hz.id_is_branch = br;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic plain();
      drv(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic branch();
      drv(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
   endtask

   task automatic br_res(bit r, bit t);
      hz.ex_br_resolved = r;
      hz.ex_br_taken    = t;
   endtask

   initial begin
      idle();
      br_res(1'b0, 1'b0);
      hz.int_req = 1'b0;
      hz.int_en  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
      #2 lit("reset_hold", o(1, 0, 0, 0, 0));
      step(); rst_n = 1'b1; idle();
      #2 lit("reset_idle", o(1, 0, 0, 0, 0));

      // RAW on x against a write to r5
      step(); drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
      #2 lit("first_issue", o(0, 0, 0, 0, 0));
      step(); drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      #2 lit("raw_c1", o(1, 0, 1, 0, 0));
      step(); #2 lit("raw_c2", o(1, 0, 1, 0, 0));
      step(); #2 lit("raw_release", o(0, 0, 0, 0, 0));

      // No false hazard: r6 on x, r5 on unused y
      step(); drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
      step(); drv(1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
      #2 lit("no_false_raw", o(0, 0, 0, 0, 0));

      // r0 is an ordinary register, checked through the y port
      step(); drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
      step(); drv(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      #2 lit("r0_raw", o(1, 0, 1, 0, 0));
      step(); step();
      #2 lit("r0_release", o(0, 0, 0, 0, 0));

      // Taken branch after three wait cycles
      step(); idle();
      step(); branch();
      #2 lit("br_issue", o(0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         step(); plain();
         #2 lit("br_wait", o(1, 0, 1, 0, 0));
      end
      step(); br_res(1'b1, 1'b1);
      #2 lit("br_taken", o(1, 0, 0, 1, 0));
      step(); br_res(1'b0, 1'b0);
      #2 lit("br_flush", o(1, 0, 0, 1, 0));
      step(); #2 lit("br_done", o(0, 0, 0, 0, 0));

      // Resolve outside BR_WAIT is ignored
      step(); br_res(1'b1, 1'b1);
      #2 lit("stray_resolve", o(0, 0, 0, 0, 0));

      // Not-taken branch: decode issues in the resolve cycle
      step(); br_res(1'b0, 1'b0); branch();
      #2 lit("nt_issue_br", o(0, 0, 0, 0, 0));
      step(); plain();
      #2 lit("nt_wait", o(1, 0, 1, 0, 0));
      step(); br_res(1'b1, 1'b0);
      #2 lit("nt_resolve_issue", o(0, 0, 0, 0, 0));
      step(); br_res(1'b0, 1'b0);
      #2 lit("nt_run", o(0, 0, 0, 0, 0));

      // Interrupt acceptance from RUN
      step(); hz.int_req = 1'b1; hz.int_en = 1'b1;
      #2 lit("int_accept", o(0, 1, 1, 0, 1));
      step(); hz.int_en = 1'b0;
      #2 lit("int_entry", o(1, 0, 0, 1, 0));
      step(); #2 lit("int_flush", o(1, 0, 0, 1, 0));
      step(); hz.int_req = 1'b0;
      #2 lit("int_done", o(0, 0, 0, 0, 0));

      // Interrupt raised during BR_WAIT is deferred until RUN
      step(); branch();
      step(); plain(); hz.int_req = 1'b1; hz.int_en = 1'b1;
      #2 lit("defer_wait", o(1, 0, 1, 0, 0));
      step(); br_res(1'b1, 1'b1);
      #2 lit("defer_taken", o(1, 0, 0, 1, 0));
      step(); br_res(1'b0, 1'b0);
      #2 lit("defer_flush", o(1, 0, 0, 1, 0));
      step(); #2 lit("defer_accept", o(0, 1, 1, 0, 1));
      step(); hz.int_req = 1'b0; hz.int_en = 1'b0;
      #2 lit("defer_entry", o(1, 0, 0, 1, 0));
      step(); step();
      #2 lit("defer_done", o(0, 0, 0, 0, 0));

      // Reset mid-flush clears the scoreboard immediately
      step(); drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
      step(); plain(); br_res(1'b1, 1'b1);
      step(); br_res(1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1 lit("reset_mid_flush", o(1, 0, 0, 0, 0));
      step(); rst_n = 1'b1;
      drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
      #2 lit("post_reset_no_raw", o(0, 0, 0, 0, 0));

      step(); idle();
      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
